// File: rtl/dispatch_unit_pkg.sv
// Shared constants, opcode ranges and FSM state type for the dispatch stage.
// Imported by the dispatch unit, its CDB snoop helper and its interface.
package dispatch_unit_pkg;

    localparam int DATA_LEN_DEF   = 32;
    localparam int ADDR_LEN_DEF   = 32;
    localparam int REG_LEN_DEF    = 5;
    localparam int ROB_LEN_DEF    = 4;
    localparam int OPENUM_LEN_DEF = 6;
    localparam int N_CDB_DEF      = 2;

    // Loads and stores occupy one contiguous opcode range (LB, LH, LW, LBU, LHU, SB, SH, SW).
    localparam logic [5:0] OPENUM_NOP = 6'd0;
    localparam logic [5:0] OPENUM_LB  = 6'd20;
    localparam logic [5:0] OPENUM_SW  = 6'd27;

    localparam logic [3:0] ROB_TAG_READY = 4'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } disp_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op >= OPENUM_LB) && (op <= OPENUM_SW);
    endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Fetch/decode to dispatch handshake: instruction offer plus its decoded fields.
// The master side is the fetcher/decoder; the slave side is the dispatch unit.
interface dispatch_unit_if
    import dispatch_unit_pkg::*;
#(
    parameter int DATA_LEN   = DATA_LEN_DEF,
    parameter int ADDR_LEN   = ADDR_LEN_DEF,
    parameter int REG_LEN    = REG_LEN_DEF,
    parameter int OPENUM_LEN = OPENUM_LEN_DEF
);
    logic                  inst_valid_from_if;
    logic                  ready_to_if;
    logic [ADDR_LEN-1:0]   pc_from_if;
    logic [OPENUM_LEN-1:0] openum_from_dcd;
    logic [REG_LEN-1:0]    rd_from_dcd;
    logic [REG_LEN-1:0]    rs1_from_dcd;
    logic [REG_LEN-1:0]    rs2_from_dcd;
    logic [DATA_LEN-1:0]   imm_from_dcd;

    modport master (
        output inst_valid_from_if, pc_from_if, openum_from_dcd,
               rd_from_dcd, rs1_from_dcd, rs2_from_dcd, imm_from_dcd,
        input  ready_to_if
    );

    modport slave (
        input  inst_valid_from_if, pc_from_if, openum_from_dcd,
               rd_from_dcd, rs1_from_dcd, rs2_from_dcd, imm_from_dcd,
        output ready_to_if
    );
endinterface

// File: rtl/dispatch_unit_cdb_snoop.sv
// Resolves one operand against the broadcast channels: a waiting tag that matches
// a valid channel takes that channel's value and becomes ready.
module dispatch_unit_cdb_snoop
    import dispatch_unit_pkg::*;
#(
    parameter int N_CDB    = N_CDB_DEF,
    parameter int ROB_LEN  = ROB_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic [ROB_LEN-1:0]        q,
    input  logic [DATA_LEN-1:0]       v,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*ROB_LEN-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_LEN-1:0] cdb_value,
    output logic [ROB_LEN-1:0]        q_res,
    output logic [DATA_LEN-1:0]       v_res
);
    localparam logic [ROB_LEN-1:0] TAG_READY = ROB_LEN'(ROB_TAG_READY);

    // Scan from the top channel down so the lowest-index match is applied last and wins.
    always_comb begin
        q_res = q;
        v_res = v;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if ((q != TAG_READY) && cdb_valid[i] && (cdb_tag[i*ROB_LEN +: ROB_LEN] == q)) begin
                q_res = TAG_READY;
                v_res = cdb_value[i*DATA_LEN +: DATA_LEN];
            end else begin
                q_res = q_res;
            end
        end
    end
endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: holds one decoded instruction, allocates its ROB tag, renames rd,
// resolves operands (regfile, rename bypass, CDB) and issues to the RS or LSQ.
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int DATA_LEN   = DATA_LEN_DEF,
    parameter int ADDR_LEN   = ADDR_LEN_DEF,
    parameter int REG_LEN    = REG_LEN_DEF,
    parameter int ROB_LEN    = ROB_LEN_DEF,
    parameter int OPENUM_LEN = OPENUM_LEN_DEF,
    parameter int N_CDB      = N_CDB_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rollback,
    dispatch_unit_if.slave            fe,
    output logic [REG_LEN-1:0]        rs1_to_reg,
    output logic [REG_LEN-1:0]        rs2_to_reg,
    input  logic [DATA_LEN-1:0]       V1_from_reg,
    input  logic [DATA_LEN-1:0]       V2_from_reg,
    input  logic [ROB_LEN-1:0]        Q1_from_reg,
    input  logic [ROB_LEN-1:0]        Q2_from_reg,
    output logic                      rename_en_to_reg,
    output logic [REG_LEN-1:0]        rename_rd_to_reg,
    output logic [ROB_LEN-1:0]        rename_tag_to_reg,
    input  logic                      rob_full,
    input  logic [ROB_LEN-1:0]        rob_free_tag,
    output logic                      alloc_to_rob,
    output logic [OPENUM_LEN-1:0]     openum_to_rob,
    output logic [REG_LEN-1:0]        rd_to_rob,
    output logic [ADDR_LEN-1:0]       pc_to_rob,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*ROB_LEN-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_LEN-1:0] cdb_value,
    input  logic                      rs_full,
    input  logic                      lsq_full,
    output logic                      issue_to_rs,
    output logic                      issue_to_lsq,
    output logic [OPENUM_LEN-1:0]     openum_out,
    output logic [DATA_LEN-1:0]       V1_out,
    output logic [DATA_LEN-1:0]       V2_out,
    output logic [ROB_LEN-1:0]        Q1_out,
    output logic [ROB_LEN-1:0]        Q2_out,
    output logic [DATA_LEN-1:0]       imm_out,
    output logic [ADDR_LEN-1:0]       pc_out,
    output logic [ROB_LEN-1:0]        dest_tag_out
);
    disp_state_e state_r, state_nxt_s;

    logic [OPENUM_LEN-1:0] op_r;
    logic [REG_LEN-1:0]    rd_r;
    logic [DATA_LEN-1:0]   imm_r, v1_r, v2_r;
    logic [ADDR_LEN-1:0]   pc_r;
    logic [ROB_LEN-1:0]    q1_r, q2_r;

    logic is_mem_s, target_full_s, issue_fire_s, ready_s, accept_s;
    logic [ROB_LEN-1:0]  q1_pre_s, q2_pre_s, q1_acc_s, q2_acc_s, q1_hold_s, q2_hold_s;
    logic [DATA_LEN-1:0] v1_pre_s, v2_pre_s, v1_acc_s, v2_acc_s, v1_hold_s, v2_hold_s;

    // Issue/accept handshake; rollback blocks both in the cycle it is raised.
    always_comb begin
        is_mem_s      = is_mem_op(op_r);
        target_full_s = is_mem_s ? lsq_full : rs_full;
        issue_fire_s  = (state_r == ST_HOLD) && !rob_full && !target_full_s && !rollback;
        ready_s       = !rollback && ((state_r == ST_IDLE) || issue_fire_s);
        accept_s      = fe.inst_valid_from_if && ready_s && (fe.openum_from_dcd != OPENUM_NOP);
    end

    assign fe.ready_to_if      = ready_s;
    assign rs1_to_reg          = fe.rs1_from_dcd;
    assign rs2_to_reg          = fe.rs2_from_dcd;
    assign alloc_to_rob        = issue_fire_s;
    assign openum_to_rob       = op_r;
    assign rd_to_rob           = rd_r;
    assign pc_to_rob           = pc_r;
    assign rename_en_to_reg    = issue_fire_s && (rd_r != {REG_LEN{1'b0}});
    assign rename_rd_to_reg    = rd_r;
    assign rename_tag_to_reg   = rob_free_tag;

    // The regfile still shows the pre-rename tag for rd this cycle, so patch it in here.
    always_comb begin
        if (rename_en_to_reg && (fe.rs1_from_dcd == rd_r)) begin
            q1_pre_s = rob_free_tag;
            v1_pre_s = {DATA_LEN{1'b0}};
        end else begin
            q1_pre_s = Q1_from_reg;
            v1_pre_s = V1_from_reg;
        end
        if (rename_en_to_reg && (fe.rs2_from_dcd == rd_r)) begin
            q2_pre_s = rob_free_tag;
            v2_pre_s = {DATA_LEN{1'b0}};
        end else begin
            q2_pre_s = Q2_from_reg;
            v2_pre_s = V2_from_reg;
        end
    end

    dispatch_unit_cdb_snoop #(.N_CDB(N_CDB), .ROB_LEN(ROB_LEN), .DATA_LEN(DATA_LEN)) u_snoop_acc1 (
        .q(q1_pre_s), .v(v1_pre_s), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .q_res(q1_acc_s), .v_res(v1_acc_s)
    );
    dispatch_unit_cdb_snoop #(.N_CDB(N_CDB), .ROB_LEN(ROB_LEN), .DATA_LEN(DATA_LEN)) u_snoop_acc2 (
        .q(q2_pre_s), .v(v2_pre_s), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .q_res(q2_acc_s), .v_res(v2_acc_s)
    );
    dispatch_unit_cdb_snoop #(.N_CDB(N_CDB), .ROB_LEN(ROB_LEN), .DATA_LEN(DATA_LEN)) u_snoop_hold1 (
        .q(q1_r), .v(v1_r), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .q_res(q1_hold_s), .v_res(v1_hold_s)
    );
    dispatch_unit_cdb_snoop #(.N_CDB(N_CDB), .ROB_LEN(ROB_LEN), .DATA_LEN(DATA_LEN)) u_snoop_hold2 (
        .q(q2_r), .v(v2_r), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .q_res(q2_hold_s), .v_res(v2_hold_s)
    );

    // Next-state logic for the pending-register FSM.
    always_comb begin
        state_nxt_s = state_r;
        if (rollback) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = accept_s ? ST_HOLD : ST_IDLE;
                ST_HOLD: begin
                    if (accept_s) begin
                        state_nxt_s = ST_HOLD;
                    end else if (issue_fire_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending instruction: load on accept, otherwise keep snooping the CDB while held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r  <= {OPENUM_LEN{1'b0}};
            rd_r  <= {REG_LEN{1'b0}};
            imm_r <= {DATA_LEN{1'b0}};
            pc_r  <= {ADDR_LEN{1'b0}};
            v1_r  <= {DATA_LEN{1'b0}};
            v2_r  <= {DATA_LEN{1'b0}};
            q1_r  <= {ROB_LEN{1'b0}};
            q2_r  <= {ROB_LEN{1'b0}};
        end else if (accept_s) begin
            op_r  <= fe.openum_from_dcd;
            rd_r  <= fe.rd_from_dcd;
            imm_r <= fe.imm_from_dcd;
            pc_r  <= fe.pc_from_if;
            v1_r  <= v1_acc_s;
            v2_r  <= v2_acc_s;
            q1_r  <= q1_acc_s;
            q2_r  <= q2_acc_s;
        end else if (state_r == ST_HOLD) begin
            v1_r  <= v1_hold_s;
            v2_r  <= v2_hold_s;
            q1_r  <= q1_hold_s;
            q2_r  <= q2_hold_s;
        end
    end

    // Issue strobes and payload; payload takes the snooped operands so a same-cycle broadcast lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_to_rs  <= 1'b0;
            issue_to_lsq <= 1'b0;
            openum_out   <= {OPENUM_LEN{1'b0}};
            V1_out       <= {DATA_LEN{1'b0}};
            V2_out       <= {DATA_LEN{1'b0}};
            Q1_out       <= {ROB_LEN{1'b0}};
            Q2_out       <= {ROB_LEN{1'b0}};
            imm_out      <= {DATA_LEN{1'b0}};
            pc_out       <= {ADDR_LEN{1'b0}};
            dest_tag_out <= {ROB_LEN{1'b0}};
        end else if (rollback) begin
            issue_to_rs  <= 1'b0;
            issue_to_lsq <= 1'b0;
        end else begin
            issue_to_rs  <= issue_fire_s && !is_mem_s;
            issue_to_lsq <= issue_fire_s && is_mem_s;
            if (issue_fire_s) begin
                openum_out   <= op_r;
                V1_out       <= v1_hold_s;
                V2_out       <= v2_hold_s;
                Q1_out       <= q1_hold_s;
                Q2_out       <= q2_hold_s;
                imm_out      <= imm_r;
                pc_out       <= pc_r;
                dest_tag_out <= rob_free_tag;
            end
        end
    end
endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: issue, stall, rename bypass, CDB capture,
// rollback, NOP dropping and reset while holding an instruction.
module tb_dispatch_unit;
    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd22;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rollback = 1'b0;
    logic [4:0]  rs1_to_reg, rs2_to_reg;
    logic [31:0] V1_from_reg = 32'd0, V2_from_reg = 32'd0;
    logic [3:0]  Q1_from_reg = 4'd0, Q2_from_reg = 4'd0;
    logic        rename_en_to_reg;
    logic [4:0]  rename_rd_to_reg;
    logic [3:0]  rename_tag_to_reg;
    logic        rob_full = 1'b0;
    logic [3:0]  rob_free_tag = 4'd1;
    logic        alloc_to_rob;
    logic [5:0]  openum_to_rob;
    logic [4:0]  rd_to_rob;
    logic [31:0] pc_to_rob;
    logic [1:0]  cdb_valid = 2'b00;
    logic [7:0]  cdb_tag = 8'd0;
    logic [63:0] cdb_value = 64'd0;
    logic        rs_full = 1'b0, lsq_full = 1'b0;
    logic        issue_to_rs, issue_to_lsq;
    logic [5:0]  openum_out;
    logic [31:0] V1_out, V2_out, imm_out, pc_out;
    logic [3:0]  Q1_out, Q2_out, dest_tag_out;

    int checks = 0;
    int errors = 0;

    dispatch_unit_if fe ();

    dispatch_unit dut (
        .clk(clk), .rst(rst), .rollback(rollback), .fe(fe),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
        .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
        .rename_en_to_reg(rename_en_to_reg), .rename_rd_to_reg(rename_rd_to_reg),
        .rename_tag_to_reg(rename_tag_to_reg),
        .rob_full(rob_full), .rob_free_tag(rob_free_tag),
        .alloc_to_rob(alloc_to_rob), .openum_to_rob(openum_to_rob),
        .rd_to_rob(rd_to_rob), .pc_to_rob(pc_to_rob),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs_full(rs_full), .lsq_full(lsq_full),
        .issue_to_rs(issue_to_rs), .issue_to_lsq(issue_to_lsq),
        .openum_out(openum_out), .V1_out(V1_out), .V2_out(V2_out),
        .Q1_out(Q1_out), .Q2_out(Q2_out), .imm_out(imm_out),
        .pc_out(pc_out), .dest_tag_out(dest_tag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
        fe.inst_valid_from_if = 1'b1;
        fe.openum_from_dcd    = op;
        fe.rd_from_dcd        = rd;
        fe.rs1_from_dcd       = rs1;
        fe.rs2_from_dcd       = rs2;
        fe.imm_from_dcd       = imm;
        fe.pc_from_if         = pc;
    endtask

    initial begin
        fe.inst_valid_from_if = 1'b0;
        fe.openum_from_dcd    = OP_NOP;
        fe.rd_from_dcd        = 5'd0;
        fe.rs1_from_dcd       = 5'd0;
        fe.rs2_from_dcd       = 5'd0;
        fe.imm_from_dcd       = 32'd0;
        fe.pc_from_if         = 32'd0;

        // Reset state
        #1;
        chk("rst_issue_rs", {63'd0, issue_to_rs}, 64'd0);
        chk("rst_issue_lsq", {63'd0, issue_to_lsq}, 64'd0);
        chk("rst_alloc", {63'd0, alloc_to_rob}, 64'd0);
        chk("rst_rename_en", {63'd0, rename_en_to_reg}, 64'd0);
        chk("rst_dest_tag", {60'd0, dest_tag_out}, 64'd0);
        chk("rst_v1_out", {32'd0, V1_out}, 64'd0);
        tick();
        rst = 1'b1;

        // 1: add x3,x1,x2 -> RS issue with regfile values and tag 3
        offer(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h100);
        V1_from_reg = 32'd5; V2_from_reg = 32'd7; rob_free_tag = 4'd3;
        #1;
        chk("t1_ready", {63'd0, fe.ready_to_if}, 64'd1);
        chk("t1_rs1_idx", {59'd0, rs1_to_reg}, 64'd1);
        tick();
        fe.inst_valid_from_if = 1'b0;
        #1;
        chk("t1_alloc", {63'd0, alloc_to_rob}, 64'd1);
        chk("t1_rename_en", {63'd0, rename_en_to_reg}, 64'd1);
        chk("t1_rename_rd", {59'd0, rename_rd_to_reg}, 64'd3);
        chk("t1_rename_tag", {60'd0, rename_tag_to_reg}, 64'd3);
        chk("t1_no_early_issue", {63'd0, issue_to_rs}, 64'd0);
        tick();
        #1;
        chk("t1_issue_rs", {63'd0, issue_to_rs}, 64'd1);
        chk("t1_issue_lsq", {63'd0, issue_to_lsq}, 64'd0);
        chk("t1_v1", {32'd0, V1_out}, 64'd5);
        chk("t1_v2", {32'd0, V2_out}, 64'd7);
        chk("t1_dest", {60'd0, dest_tag_out}, 64'd3);
        chk("t1_op", {58'd0, openum_out}, 64'd1);
        chk("t1_pc", {32'd0, pc_out}, 64'h100);
        chk("t1_alloc_done", {63'd0, alloc_to_rob}, 64'd0);
        tick();
        #1;
        chk("t1_one_shot", {63'd0, issue_to_rs}, 64'd0);

        // 2: lw stalled 3 cycles by lsq_full, then one LSQ issue
        offer(OP_LW, 5'd4, 5'd1, 5'd0, 32'd8, 32'h104);
        rob_free_tag = 4'd5; lsq_full = 1'b1;
        #1;
        tick();
        fe.inst_valid_from_if = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_ready_stall", {63'd0, fe.ready_to_if}, 64'd0);
            chk("t2_alloc_stall", {63'd0, alloc_to_rob}, 64'd0);
            chk("t2_lsq_stall", {63'd0, issue_to_lsq}, 64'd0);
            tick();
            #1;
        end
        lsq_full = 1'b0;
        #1;
        chk("t2_alloc", {63'd0, alloc_to_rob}, 64'd1);
        tick();
        #1;
        chk("t2_issue_lsq", {63'd0, issue_to_lsq}, 64'd1);
        chk("t2_issue_rs", {63'd0, issue_to_rs}, 64'd0);
        chk("t2_imm", {32'd0, imm_out}, 64'd8);
        chk("t2_dest", {60'd0, dest_tag_out}, 64'd5);
        chk("t2_op", {58'd0, openum_out}, 64'd22);
        tick();
        #1;
        chk("t2_one_shot", {63'd0, issue_to_lsq}, 64'd0);

        // 3: add x5 then sub x6,x5,x5 back to back -> rename bypass gives tag 6
        offer(OP_ADD, 5'd5, 5'd1, 5'd2, 32'd0, 32'h108);
        V1_from_reg = 32'd1; V2_from_reg = 32'd2; rob_free_tag = 4'd6;
        #1;
        tick();
        offer(OP_SUB, 5'd6, 5'd5, 5'd5, 32'd0, 32'h10C);
        Q1_from_reg = 4'd2; Q2_from_reg = 4'd2; V1_from_reg = 32'd9; V2_from_reg = 32'd9;
        #1;
        chk("t3_ready_stream", {63'd0, fe.ready_to_if}, 64'd1);
        chk("t3_rename_tag", {60'd0, rename_tag_to_reg}, 64'd6);
        tick();
        fe.inst_valid_from_if = 1'b0;
        Q1_from_reg = 4'd0; Q2_from_reg = 4'd0; rob_free_tag = 4'd7;
        #1;
        chk("t3_first_issue", {63'd0, issue_to_rs}, 64'd1);
        chk("t3_first_dest", {60'd0, dest_tag_out}, 64'd6);
        tick();
        #1;
        chk("t3_second_issue", {63'd0, issue_to_rs}, 64'd1);
        chk("t3_q1_bypass", {60'd0, Q1_out}, 64'd6);
        chk("t3_q2_bypass", {60'd0, Q2_out}, 64'd6);
        chk("t3_v1_zero", {32'd0, V1_out}, 64'd0);
        chk("t3_second_dest", {60'd0, dest_tag_out}, 64'd7);

        // 4: operand waiting on tag 4 captures channel-1 broadcast while stalled
        tick();
        offer(OP_ADD, 5'd7, 5'd8, 5'd9, 32'd0, 32'h110);
        Q1_from_reg = 4'd4; V1_from_reg = 32'd0; V2_from_reg = 32'h11;
        rob_free_tag = 4'd8; rs_full = 1'b1;
        #1;
        tick();
        fe.inst_valid_from_if = 1'b0; Q1_from_reg = 4'd0;
        cdb_valid = 2'b10; cdb_tag = {4'd4, 4'd0}; cdb_value = {32'hDEAD, 32'h0};
        #1;
        chk("t4_stalled", {63'd0, issue_to_rs}, 64'd0);
        tick();
        cdb_valid = 2'b00; cdb_value = 64'd0;
        tick();
        rs_full = 1'b0;
        #1;
        tick();
        #1;
        chk("t4_issue", {63'd0, issue_to_rs}, 64'd1);
        chk("t4_v1_cdb", {32'd0, V1_out}, 64'hDEAD);
        chk("t4_q1_ready", {60'd0, Q1_out}, 64'd0);
        chk("t4_v2", {32'd0, V2_out}, 64'h11);

        // 4b: accept-path CDB capture, then issue-cycle bypass with duplicate tags (ch0 wins)
        tick();
        offer(OP_ADD, 5'd9, 5'd10, 5'd11, 32'd0, 32'h114);
        Q1_from_reg = 4'd3; V1_from_reg = 32'h99; Q2_from_reg = 4'd5; V2_from_reg = 32'd0;
        rob_free_tag = 4'd9;
        cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_value = {32'h33, 32'h0};
        #1;
        tick();
        fe.inst_valid_from_if = 1'b0; Q1_from_reg = 4'd0; Q2_from_reg = 4'd0;
        cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_value = {32'hCAFE, 32'hBEEF};
        #1;
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("t4b_issue", {63'd0, issue_to_rs}, 64'd1);
        chk("t4b_v1_accept_cdb", {32'd0, V1_out}, 64'h33);
        chk("t4b_q1", {60'd0, Q1_out}, 64'd0);
        chk("t4b_v2_low_ch", {32'd0, V2_out}, 64'hBEEF);
        chk("t4b_q2", {60'd0, Q2_out}, 64'd0);

        // 5: rollback while stalled on rob_full
        tick();
        offer(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h118);
        rob_full = 1'b1;
        #1;
        tick();
        fe.inst_valid_from_if = 1'b0;
        #1;
        chk("t5_alloc_full", {63'd0, alloc_to_rob}, 64'd0);
        chk("t5_ready_hold", {63'd0, fe.ready_to_if}, 64'd0);
        rollback = 1'b1;
        #1;
        chk("t5_ready_rb", {63'd0, fe.ready_to_if}, 64'd0);
        chk("t5_rename_rb", {63'd0, rename_en_to_reg}, 64'd0);
        tick();
        rollback = 1'b0; rob_full = 1'b0;
        #1;
        chk("t5_no_issue", {63'd0, issue_to_rs}, 64'd0);
        chk("t5_ready_back", {63'd0, fe.ready_to_if}, 64'd1);
        chk("t5_no_alloc", {63'd0, alloc_to_rob}, 64'd0);
        tick();
        #1;
        chk("t5_still_idle", {63'd0, issue_to_rs}, 64'd0);

        // 6: four NOPs are consumed without allocation or issue
        offer(OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'h11C);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_ready", {63'd0, fe.ready_to_if}, 64'd1);
            chk("t6_alloc", {63'd0, alloc_to_rob}, 64'd0);
            chk("t6_issue", {62'd0, issue_to_rs, issue_to_lsq}, 64'd0);
            tick();
        end
        fe.inst_valid_from_if = 1'b0;
        #1;
        chk("t6_idle_alloc", {63'd0, alloc_to_rob}, 64'd0);
        chk("t6_idle_issue", {62'd0, issue_to_rs, issue_to_lsq}, 64'd0);

        // 7: reset while holding drops the instruction and clears the payload
        offer(OP_ADD, 5'd2, 5'd1, 5'd1, 32'd0, 32'h120);
        rs_full = 1'b1;
        #1;
        tick();
        fe.inst_valid_from_if = 1'b0;
        rst = 1'b0;
        #1;
        chk("t7_rst_v1", {32'd0, V1_out}, 64'd0);
        chk("t7_rst_dest", {60'd0, dest_tag_out}, 64'd0);
        rst = 1'b1; rs_full = 1'b0;
        #1;
        chk("t7_dropped_alloc", {63'd0, alloc_to_rob}, 64'd0);
        tick();
        #1;
        chk("t7_dropped_issue", {63'd0, issue_to_rs}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Dispatch stage of the Tomasulo core, between fetcher/decoder and the back end (ROB, reservation station, load/store queue, register file).
- Holds one decoded instruction in a pending register and allocates a ROB tag for it.
- Resolves operands from the register file and from N_CDB snooped broadcast channels, including same-cycle rename bypass.
- Issues to RS or LSQ under full/stall back-pressure; rollback flushes it.

Parameters:
- DATA_LEN, 32, operand/value width
- ADDR_LEN, 32, pc width
- REG_LEN, 5, architectural register index width
- ROB_LEN, 4, ROB tag width; tag 0 reserved = "value ready"
- OPENUM_LEN, 6, decoded opcode enum width
- N_CDB, 2, number of broadcast channels snooped (ALU, LSB, ...)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rollback  in  1  misprediction flush
- inst_valid_from_if  in  1  fetcher offers an instruction
- ready_to_if  out  1  dispatcher accepts this cycle
- pc_from_if  in  ADDR_LEN  pc of offered instruction
- openum_from_dcd  in  OPENUM_LEN  decoded op (combinational decoder)
- rd_from_dcd / rs1_from_dcd / rs2_from_dcd  in  REG_LEN each  register indices
- imm_from_dcd  in  DATA_LEN  immediate
- rs1_to_reg / rs2_to_reg  out  REG_LEN each  regfile read indices
- V1_from_reg / V2_from_reg  in  DATA_LEN each  regfile values
- Q1_from_reg / Q2_from_reg  in  ROB_LEN each  regfile rename tags
- rename_en_to_reg  out  1  write rename tag
- rename_rd_to_reg  out  REG_LEN  register being renamed
- rename_tag_to_reg  out  ROB_LEN  new tag
- rob_full  in  1  ROB cannot allocate
- rob_free_tag  in  ROB_LEN  tag ROB will assign on alloc (never 0)
- alloc_to_rob  out  1  allocate entry
- openum_to_rob  out  OPENUM_LEN  entry opcode
- rd_to_rob  out  REG_LEN  entry destination
- pc_to_rob  out  ADDR_LEN  entry pc
- cdb_valid  in  N_CDB  broadcast valid per channel
- cdb_tag  in  N_CDB*ROB_LEN  packed tags, channel 0 in LSBs
- cdb_value  in  N_CDB*DATA_LEN  packed values
- rs_full / lsq_full  in  1 each  target cannot accept
- issue_to_rs / issue_to_lsq  out  1 each  one-cycle issue strobes
- openum_out  out  OPENUM_LEN  shared issue payload
- V1_out / V2_out  out  DATA_LEN each  shared issue payload
- Q1_out / Q2_out  out  ROB_LEN each  shared issue payload
- imm_out  out  DATA_LEN  shared issue payload
- pc_out  out  ADDR_LEN  shared issue payload
- dest_tag_out  out  ROB_LEN  shared issue payload

Behaviour:
- Reset (rst=0, async): pending_valid=0; issue_to_rs, issue_to_lsq, alloc_to_rob, rename_en_to_reg = 0; every payload output = 0.
- FSM, two states:
  - IDLE: no pending instruction.
  - HOLD: pending register valid.
- Fire condition: issue_fire = HOLD & !rob_full & !(is_mem ? lsq_full : rs_full).
  - is_mem = openum in OPENUM_LB..OPENUM_SW.
  - All other non-NOP ops go to the RS.
- ready_to_if = IDLE | issue_fire. This is combinational and sustains 1 instr/cycle.
- Accept: inst_valid_from_if & ready_to_if & openum != OPENUM_NOP. Latch openum, rd, imm, pc and operands at the edge, then go to HOLD. A NOP is consumed and dropped with no ROB allocation.
- Issue cycle (issue_fire):
  - Combinationally assert alloc_to_rob.
  - Assert rename_en_to_reg iff rd != 0.
  - At the edge, register issue_to_rs or issue_to_lsq = 1 for exactly one cycle, with payload and dest_tag_out = rob_free_tag.
  - If no new accept occurs, return to IDLE.
- Operand resolution on accept, per operand k:
  - Step 1: if rsk matches the instruction renamed this same cycle (rename_en_to_reg & rsk == rename_rd_to_reg), use Q = rename_tag_to_reg, V = 0.
  - Step 2: otherwise use the regfile Q/V.
  - Step 3: if the resulting Q != 0 and some channel has cdb_valid with a matching tag, take V = cdb_value and set Q = 0. The lowest-index channel wins on duplicates.
- While in HOLD: every cycle, snoop each operand with Q != 0 against the CDB and capture the value into the pending register.
- Issue payload bypass: the issue payload also applies the same-cycle CDB match, so a broadcast on the issue cycle is never lost.
- Rollback (async-free, sampled at the edge): highest priority.
  - Clears pending and issue strobes next edge.
  - Suppresses alloc_to_rob, rename and accept in that cycle.
  - ready_to_if = 0 while rollback = 1.
- Stall: with rob_full or target full, HOLD persists, the payload is stable and snooping continues.
- Reset mid-HOLD: the pending instruction is dropped.

Decomposition:
- defines.v gains:
  - OPENUM range macros and OPENUM_NOP (existing).
  - ROB_TAG_READY = 0.
  - Macro IS_MEM_OP(op).
- Sub-module cdb_snoop: parameterised on N_CDB, ROB_LEN and DATA_LEN.
  - Inputs: Q, V and the CDB buses.
  - Outputs: resolved Q and V.
  - Instantiated 4 times: accept path and hold path, for each of the two operands.

Test Plan:
1. Reset, then add x3,x1,x2 with regfile Q1=Q2=0, V1=5, V2=7, rob_free_tag=3 -> one cycle after accept issue_to_rs=1, V1_out=5, V2_out=7, dest_tag_out=3; rename_rd_to_reg=3 seen during the issue cycle.
2. lw with lsq_full=1 for 3 cycles -> ready_to_if=0, no strobe and no alloc for 3 cycles; lsq_full drops -> issue_to_lsq=1 once.
3. Back-to-back add x5,.. then sub x6,x5,x5 -> second instruction issues with Q1=Q2 equal to the first instruction's tag (rename bypass), not the stale regfile tag.
4. Hold with Q1=4 while stalled; cdb_valid[1]=1, cdb_tag ch1=4, value 0xDEAD -> issued V1_out=0xDEAD, Q1_out=0.
5. rollback asserted while in HOLD with rob_full=1 -> next cycle IDLE, no issue or alloc strobe; ready_to_if returns to 1 after rollback deasserts.
6. Stream of 4 NOPs -> all accepted, ready_to_if held at 1, zero allocations or issues.
